// File: rtl/pps_pkg.sv
// Shared types and helpers for the PPS frequency discipline loop.
package pps_pkg;

    localparam int INCR_W = 32;
    localparam int ERR_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_TRACK    = 2'd2,
        ST_HOLDOVER = 2'd3
    } pps_state_e;

    // One closed PPS period handed from the counter to the servo pipeline.
    typedef struct packed {
        logic              vld;
        logic [INCR_W-1:0] cnt;
    } pps_sample_t;

    function automatic logic signed [ERR_W-1:0] sat_s33(input logic signed [ERR_W:0] v);
        if (v[ERR_W] != v[ERR_W-1])
            return v[ERR_W] ? {1'b1, {(ERR_W-1){1'b0}}} : {1'b0, {(ERR_W-1){1'b1}}};
        return v[ERR_W-1:0];
    endfunction

endpackage

// File: rtl/pps_servo_calc.sv
// Servo pipeline: capture -> period error -> gain/clamp/apply, with lock tracking.
module pps_servo_calc
    import pps_pkg::*;
#(
    parameter logic [INCR_W-1:0] INCR_NOMINAL   = '0,
    parameter logic [INCR_W-1:0] INCR_MIN       = '0,
    parameter logic [INCR_W-1:0] INCR_MAX       = '1,
    parameter int unsigned       EXPECTED_TICKS = 1000,
    parameter int unsigned       KP_SHIFT       = 4,
    parameter int unsigned       MAX_STEP       = 4096,
    parameter int unsigned       LOCK_WINDOW    = 2,
    parameter int unsigned       LOCK_COUNT     = 3
) (
    input  logic              clk_pps,
    input  logic              reset_pps,
    input  logic              flush,
    input  logic              freeze,
    input  logic              hold_clr,
    input  pps_sample_t       sample,
    output logic [INCR_W-1:0] accum_incr,
    output logic              incr_update,
    output logic [ERR_W-1:0]  period_err,
    output logic              locked
);

    localparam int STAGES = 2;
    localparam logic signed [ERR_W:0]   EXP_S  = (ERR_W+1)'(EXPECTED_TICKS);
    localparam logic signed [47:0]      STEP_P = 48'(MAX_STEP);
    localparam logic signed [47:0]      STEP_N = -STEP_P;
    localparam logic signed [33:0]      STEP_P34 = 34'(MAX_STEP);
    localparam logic signed [33:0]      STEP_N34 = -STEP_P34;
    localparam logic signed [ERR_W-1:0] WIN_P  = ERR_W'(LOCK_WINDOW);
    localparam logic signed [ERR_W-1:0] WIN_N  = -WIN_P;
    localparam logic signed [33:0]      MIN_S  = {2'b00, INCR_MIN};
    localparam logic signed [33:0]      MAX_S  = {2'b00, INCR_MAX};
    localparam logic [31:0]             LCNT   = 32'(LOCK_COUNT);

    logic [STAGES:0]          vld_pipe;
    logic [INCR_W-1:0]        cap_cnt;
    logic signed [ERR_W-1:0]  err_q;
    logic signed [ERR_W-1:0]  err_next;
    logic signed [47:0]       corr_full;
    logic signed [33:0]       corr;
    logic signed [33:0]       incr_sum;
    logic [INCR_W-1:0]        incr_next;
    logic                     in_win;
    logic [31:0]              lock_cnt;

    always_comb begin
        err_next  = sat_s33(EXP_S - $signed({1'b0, cap_cnt}));
        corr_full = $signed({{(48-ERR_W){err_q[ERR_W-1]}}, err_q}) <<< KP_SHIFT;
        if (corr_full > STEP_P)
            corr = STEP_P34;
        else if (corr_full < STEP_N)
            corr = STEP_N34;
        else
            corr = corr_full[33:0];
        incr_sum = $signed({2'b00, accum_incr}) + corr;
        if (incr_sum > MAX_S)
            incr_next = INCR_MAX;
        else if (incr_sum < MIN_S)
            incr_next = INCR_MIN;
        else
            incr_next = incr_sum[INCR_W-1:0];
        in_win = (err_q <= WIN_P) && (err_q >= WIN_N);
    end

    always_ff @(posedge clk_pps or posedge reset_pps) begin
        if (reset_pps) begin
            vld_pipe   <= '0;
            cap_cnt    <= '0;
            err_q      <= '0;
            accum_incr <= INCR_NOMINAL;
            locked     <= 1'b0;
            lock_cnt   <= '0;
        end else begin
            // A frozen loop lets the final stage drain without writing.
            vld_pipe <= flush ? '0 : {vld_pipe[STAGES-1] & ~freeze, vld_pipe[STAGES-2:0], sample.vld};
            if (sample.vld)
                cap_cnt <= sample.cnt;
            if (vld_pipe[0] && !flush)
                err_q <= err_next;
            if (flush) begin
                accum_incr <= INCR_NOMINAL;
                locked     <= 1'b0;
                lock_cnt   <= '0;
            end else begin
                if (vld_pipe[STAGES-1] && !freeze) begin
                    accum_incr <= incr_next;
                    if (in_win) begin
                        if (lock_cnt < LCNT)
                            lock_cnt <= lock_cnt + 32'd1;
                        locked <= (lock_cnt + 32'd1 >= LCNT);
                    end else begin
                        lock_cnt <= '0;
                        locked   <= 1'b0;
                    end
                end
                // Holdover entry still lets a coincident increment write land.
                if (hold_clr) begin
                    locked   <= 1'b0;
                    lock_cnt <= '0;
                end
            end
        end
    end

    assign period_err  = err_q;
    assign incr_update = vld_pipe[STAGES];

endmodule

// File: rtl/pps_discipline_ctrl.sv
// PPS discipline loop top: mode FSM, PPS watchdog and carry counter feeding the servo.
module pps_discipline_ctrl
    import pps_pkg::*;
#(
    parameter logic [INCR_W-1:0] INCR_NOMINAL   = 32'h0000_0000,
    parameter logic [INCR_W-1:0] INCR_MIN       = 32'h0000_0000,
    parameter logic [INCR_W-1:0] INCR_MAX       = 32'hFFFF_FFFF,
    parameter int unsigned       EXPECTED_TICKS = 1000,
    parameter int unsigned       KP_SHIFT       = 4,
    parameter int unsigned       MAX_STEP       = 4096,
    parameter int unsigned       LOCK_WINDOW    = 2,
    parameter int unsigned       LOCK_COUNT     = 3,
    parameter int unsigned       TIMEOUT_CYCLES = 200_000_000
) (
    input  logic              clk_pps,
    input  logic              reset_pps,
    input  logic              enable,
    input  logic              pps_in_pulse,
    input  logic              carry_in,
    output logic [INCR_W-1:0] accum_incr,
    output logic              incr_update,
    output logic [ERR_W-1:0]  period_err,
    output logic              locked,
    output logic              holdover,
    output logic [1:0]        state
);

    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

    pps_state_e  st;
    logic [31:0] wd_cnt;
    logic [31:0] tick_cnt;
    logic [31:0] tick_inc;
    logic        hold_enter;
    pps_sample_t sample;

    always_comb begin
        tick_inc   = (carry_in && tick_cnt != '1) ? tick_cnt + 32'd1 : tick_cnt;
        hold_enter = enable && (st == ST_ACQUIRE || st == ST_TRACK) &&
                     !pps_in_pulse && (wd_cnt == WD_LAST);
    end

    // The coincident carry is folded into the closing period's count.
    assign sample = '{vld: enable && (st == ST_TRACK) && pps_in_pulse, cnt: tick_inc};

    always_ff @(posedge clk_pps or posedge reset_pps) begin
        if (reset_pps) begin
            st       <= ST_IDLE;
            holdover <= 1'b0;
            wd_cnt   <= '0;
            tick_cnt <= '0;
        end else if (!enable) begin
            st       <= ST_IDLE;
            holdover <= 1'b0;
            wd_cnt   <= '0;
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_inc;
            unique case (st)
                ST_IDLE: begin
                    st     <= ST_ACQUIRE;
                    wd_cnt <= '0;
                end
                ST_ACQUIRE, ST_TRACK: begin
                    if (pps_in_pulse) begin
                        st       <= ST_TRACK;
                        wd_cnt   <= '0;
                        tick_cnt <= '0;
                    end else if (hold_enter) begin
                        st       <= ST_HOLDOVER;
                        holdover <= 1'b1;
                        wd_cnt   <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
                end
                ST_HOLDOVER: begin
                    if (pps_in_pulse) begin
                        st       <= ST_ACQUIRE;
                        holdover <= 1'b0;
                        wd_cnt   <= '0;
                        tick_cnt <= '0;
                    end
                end
            endcase
        end
    end

    assign state = st;

    pps_servo_calc #(
        .INCR_NOMINAL   (INCR_NOMINAL),
        .INCR_MIN       (INCR_MIN),
        .INCR_MAX       (INCR_MAX),
        .EXPECTED_TICKS (EXPECTED_TICKS),
        .KP_SHIFT       (KP_SHIFT),
        .MAX_STEP       (MAX_STEP),
        .LOCK_WINDOW    (LOCK_WINDOW),
        .LOCK_COUNT     (LOCK_COUNT)
    ) u_servo (
        .clk_pps     (clk_pps),
        .reset_pps   (reset_pps),
        .flush       (!enable),
        .freeze      (st == ST_HOLDOVER),
        .hold_clr    (hold_enter),
        .sample      (sample),
        .accum_incr  (accum_incr),
        .incr_update (incr_update),
        .period_err  (period_err),
        .locked      (locked)
    );

endmodule

// File: tb/tb_pps_discipline_ctrl.sv
// Randomized bench for pps_discipline_ctrl against a per-measurement arithmetic model.
module tb_pps_discipline_ctrl;

    localparam logic [31:0] NOM  = 32'h2AF3_1DC4;
    localparam logic [31:0] IMAX = 32'h2AF3_2000;
    localparam longint EMAX = 2147483647;
    localparam longint EMIN = -EMAX - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0, pps = 1'b0, carry = 1'b0;

    logic [31:0] a_incr, a_err, h_incr, h_err;
    logic        a_upd, a_lock, a_hold, h_upd, h_lock, h_hold;
    logic [1:0]  a_state, h_state;

    int total = 0;
    int bad = 0;

    longint m_incr;
    int     m_lc;
    bit     m_lock;

    always #5 clk = ~clk;

    pps_discipline_ctrl #(.INCR_NOMINAL(NOM), .INCR_MAX(IMAX)) dut (
        .clk_pps(clk), .reset_pps(rst), .enable(en), .pps_in_pulse(pps), .carry_in(carry),
        .accum_incr(a_incr), .incr_update(a_upd), .period_err(a_err),
        .locked(a_lock), .holdover(a_hold), .state(a_state));

    pps_discipline_ctrl #(.INCR_NOMINAL(NOM), .INCR_MAX(IMAX), .TIMEOUT_CYCLES(50)) dut_h (
        .clk_pps(clk), .reset_pps(rst), .enable(en), .pps_in_pulse(pps), .carry_in(carry),
        .accum_incr(h_incr), .incr_update(h_upd), .period_err(h_err),
        .locked(h_lock), .holdover(h_hold), .state(h_state));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_init();
        m_incr = longint'(NOM);
        m_lc   = 0;
        m_lock = 1'b0;
    endtask

    // One measurement of n carries: error, P-correction, clamped increment, lock.
    task automatic model_meas(input longint n, output longint e);
        longint c;
        e = 1000 - n;
        if (e > EMAX) e = EMAX;
        if (e < EMIN) e = EMIN;
        c = e * 16;
        if (c > 4096) c = 4096;
        if (c < -4096) c = -4096;
        m_incr = m_incr + c;
        if (m_incr > longint'(IMAX)) m_incr = longint'(IMAX);
        if (m_incr < 0) m_incr = 0;
        if (e <= 2 && e >= -2) begin
            m_lc++;
            m_lock = (m_lc >= 3);
        end else begin
            m_lc   = 0;
            m_lock = 1'b0;
        end
    endtask

    // Leaves the bench in cycle T+1 of the closing PPS.
    task automatic run_period(input int n, input bit coinc, input int gmax);
        int pre;
        pre = coinc ? n - 1 : n;
        for (int i = 0; i < pre; i++) begin
            repeat ($urandom_range(gmax, 0)) tick();
            carry = 1'b1;
            tick();
            carry = 1'b0;
        end
        pps = 1'b1;
        carry = coinc;
        tick();
        pps = 1'b0;
        carry = 1'b0;
    endtask

    task automatic restart();
        en = 1'b0;
        tick();
        model_init();
        en = 1'b1;
        tick();
        pps = 1'b1;
        tick();
        pps = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        total++; if (a_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", a_state); end
        total++; if (a_incr !== NOM) begin bad++; $display("FAIL reset_incr got=%h want=%h", a_incr, NOM); end
        total++; if (a_upd !== 1'b0) begin bad++; $display("FAIL reset_upd got=%b want=0", a_upd); end
        total++; if (a_err !== 32'd0) begin bad++; $display("FAIL reset_err got=%h want=0", a_err); end
        total++; if (a_lock !== 1'b0 || a_hold !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", a_lock, a_hold); end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_idle();
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            run_period(20, 1'b0, 1);
            for (int j = 0; j < 4; j++) begin
                total++; if (a_upd !== 1'b0) begin bad++; $display("FAIL idle_upd got=%b want=0", a_upd); end
                tick();
            end
            total++; if (a_state !== 2'd0) begin bad++; $display("FAIL idle_state got=%0d want=0", a_state); end
            total++; if (a_incr !== NOM) begin bad++; $display("FAIL idle_incr got=%h want=%h", a_incr, NOM); end
        end
    endtask

    task automatic test_nominal();
        longint e;
        en = 1'b0;
        tick();
        model_init();
        en = 1'b1;
        tick();
        pps = 1'b1;
        tick();
        pps = 1'b0;
        for (int j = 0; j < 4; j++) begin
            total++; if (a_upd !== 1'b0) begin bad++; $display("FAIL acq_upd got=%b want=0", a_upd); end
            tick();
        end
        total++; if (a_state !== 2'd2) begin bad++; $display("FAIL acq_state got=%0d want=2", a_state); end
        for (int k = 1; k <= 4; k++) begin
            run_period(1000, 1'b0, 1);
            model_meas(1000, e);
            tick();
            total++; if (a_err !== 32'(e)) begin bad++; $display("FAIL nom_err got=%0d want=%0d", $signed(a_err), e); end
            total++; if (a_upd !== 1'b0) begin bad++; $display("FAIL nom_upd_early got=%b want=0", a_upd); end
            tick();
            total++; if (a_upd !== 1'b1) begin bad++; $display("FAIL nom_upd got=%b want=1", a_upd); end
            total++; if (a_incr !== 32'(m_incr)) begin bad++; $display("FAIL nom_incr got=%h want=%h", a_incr, 32'(m_incr)); end
            total++; if (a_lock !== m_lock) begin bad++; $display("FAIL nom_lock meas=%0d got=%b want=%b", k, a_lock, m_lock); end
            tick();
            total++; if (a_upd !== 1'b0) begin bad++; $display("FAIL nom_upd_len got=%b want=0", a_upd); end
        end
    endtask

    task automatic test_slow();
        longint e;
        restart();
        for (int k = 0; k < 2; k++) begin
            run_period(995, 1'b0, 1);
            model_meas(995, e);
            tick();
            total++; if (a_err !== 32'd5) begin bad++; $display("FAIL slow_err got=%0d want=5", $signed(a_err)); end
            tick();
            total++; if (a_incr !== 32'(m_incr)) begin bad++; $display("FAIL slow_incr got=%h want=%h", a_incr, 32'(m_incr)); end
            total++; if (k == 0 && a_incr !== 32'h2AF3_1E14) begin bad++; $display("FAIL slow_first got=%h want=2af31e14", a_incr); end
            total++; if (a_lock !== 1'b0) begin bad++; $display("FAIL slow_lock got=%b want=0", a_lock); end
        end
    endtask

    task automatic test_clamp();
        longint e;
        restart();
        run_period(100, 1'b0, 1);
        model_meas(100, e);
        tick();
        total++; if (a_err !== 32'd900) begin bad++; $display("FAIL clamp_err got=%0d want=900", $signed(a_err)); end
        tick();
        total++; if (a_incr !== IMAX) begin bad++; $display("FAIL clamp_incr got=%h want=%h", a_incr, IMAX); end
    endtask

    task automatic test_coincident();
        longint e;
        restart();
        run_period(1000, 1'b1, 1);
        model_meas(1000, e);
        tick();
        total++; if (a_err !== 32'd0) begin bad++; $display("FAIL coinc_err got=%0d want=0", $signed(a_err)); end
        tick();
        total++; if (a_incr !== NOM) begin bad++; $display("FAIL coinc_incr got=%h want=%h", a_incr, NOM); end
    endtask

    task automatic test_random();
        longint e;
        int n;
        bit c;
        restart();
        for (int k = 0; k < 10; k++) begin
            n = ($urandom_range(3, 0) == 0) ? int'($urandom_range(1100, 900)) : int'($urandom_range(1003, 997));
            c = 1'($urandom_range(1, 0));
            run_period(n, c, 1);
            model_meas(longint'(n), e);
            tick();
            total++; if (a_err !== 32'(e)) begin bad++; $display("FAIL rnd_err n=%0d got=%0d want=%0d", n, $signed(a_err), e); end
            tick();
            total++; if (a_upd !== 1'b1) begin bad++; $display("FAIL rnd_upd got=%b want=1", a_upd); end
            total++; if (a_incr !== 32'(m_incr)) begin bad++; $display("FAIL rnd_incr n=%0d got=%h want=%h", n, a_incr, 32'(m_incr)); end
            total++; if (a_lock !== m_lock) begin bad++; $display("FAIL rnd_lock n=%0d got=%b want=%b", n, a_lock, m_lock); end
        end
    endtask

    task automatic test_back_to_back();
        longint e1, e2, x1, x2;
        bit c2;
        restart();
        run_period(998, 1'b0, 1);
        model_meas(998, e1);
        x1 = m_incr;
        c2 = 1'($urandom_range(1, 0));
        pps = 1'b1;
        carry = c2;
        tick();
        pps = 1'b0;
        carry = 1'b0;
        model_meas(longint'(c2), e2);
        x2 = m_incr;
        total++; if (a_err !== 32'(e1)) begin bad++; $display("FAIL b2b_err1 got=%0d want=%0d", $signed(a_err), e1); end
        tick();
        total++; if (a_upd !== 1'b1 || a_incr !== 32'(x1)) begin bad++; $display("FAIL b2b_upd1 got=%b/%h want=1/%h", a_upd, a_incr, 32'(x1)); end
        total++; if (a_err !== 32'(e2)) begin bad++; $display("FAIL b2b_err2 got=%0d want=%0d", $signed(a_err), e2); end
        tick();
        total++; if (a_upd !== 1'b1 || a_incr !== 32'(x2)) begin bad++; $display("FAIL b2b_upd2 got=%b/%h want=1/%h", a_upd, a_incr, 32'(x2)); end
        tick();
        total++; if (a_upd !== 1'b0) begin bad++; $display("FAIL b2b_upd_end got=%b want=0", a_upd); end
    endtask

    task automatic test_enable_drop();
        longint e;
        restart();
        run_period(990, 1'b0, 1);
        model_meas(990, e);
        tick();
        tick();
        total++; if (a_incr !== 32'(m_incr)) begin bad++; $display("FAIL drop_pre got=%h want=%h", a_incr, 32'(m_incr)); end
        run_period(990, 1'b0, 1);
        en = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            total++; if (a_upd !== 1'b0) begin bad++; $display("FAIL drop_upd got=%b want=0", a_upd); end
        end
        total++; if (a_incr !== NOM) begin bad++; $display("FAIL drop_incr got=%h want=%h", a_incr, NOM); end
        total++; if (a_state !== 2'd0) begin bad++; $display("FAIL drop_state got=%0d want=0", a_state); end
    endtask

    task automatic test_reset_mid();
        restart();
        run_period(990, 1'b0, 1);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            total++; if (a_upd !== 1'b0) begin bad++; $display("FAIL rstmid_upd got=%b want=0", a_upd); end
        end
        total++; if (a_incr !== NOM) begin bad++; $display("FAIL rstmid_incr got=%h want=%h", a_incr, NOM); end
    endtask

    task automatic test_holdover();
        en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        restart();
        run_period(30, 1'b0, 0);
        tick();
        tick();
        total++; if (h_upd !== 1'b1 || h_incr !== IMAX) begin bad++; $display("FAIL ho_meas got=%b/%h want=1/%h", h_upd, h_incr, IMAX); end
        repeat (47) tick();
        total++; if (h_hold !== 1'b0 || h_state !== 2'd2) begin bad++; $display("FAIL ho_early got=%b/%0d want=0/2", h_hold, h_state); end
        tick();
        total++; if (h_hold !== 1'b1 || h_state !== 2'd3) begin bad++; $display("FAIL ho_enter got=%b/%0d want=1/3", h_hold, h_state); end
        total++; if (h_lock !== 1'b0) begin bad++; $display("FAIL ho_lock got=%b want=0", h_lock); end
        for (int j = 0; j < 10; j++) begin
            carry = 1'b1;
            tick();
        end
        carry = 1'b0;
        total++; if (h_incr !== IMAX || h_upd !== 1'b0) begin bad++; $display("FAIL ho_frozen got=%h/%b want=%h/0", h_incr, h_upd, IMAX); end
        pps = 1'b1;
        tick();
        pps = 1'b0;
        total++; if (h_state !== 2'd1 || h_hold !== 1'b0) begin bad++; $display("FAIL ho_reacq got=%0d/%b want=1/0", h_state, h_hold); end
        repeat (3) tick();
        pps = 1'b1;
        tick();
        pps = 1'b0;
        total++; if (h_state !== 2'd2) begin bad++; $display("FAIL ho_track got=%0d want=2", h_state); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        model_init();
        test_reset();
        test_idle();
        test_nominal();
        test_slow();
        test_clamp();
        test_coincident();
        test_random();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_holdover();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
